mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_pkg.sv | 24 ++
 rtl/mdu_arith.sv | 41 ++++
 rtl/mdu_ctrl.sv | 88 ++++++++
 tb/tb_mdu_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared CPU constants for the multiply/divide unit: mdOp encodings and
// default operation latencies, also used by the ID-stage decoder.
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MFHI  = 3'd6,
        MD_MFLO  = 3'd7
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Ops that occupy the unit for a timed interval.
    function automatic logic is_timed_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 32x32 multiply and 32/32 divide, signed or unsigned by op.
import mdu_ctrl_pkg::*;

module mdu_arith (
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_prod,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem,
    output logic        o_div_zero
);

    logic        w_smul;
    logic        w_sdiv;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_uq;
    logic [31:0] w_ur;

    assign w_smul = (i_op == MD_MULT);
    assign w_sdiv = (i_op == MD_DIV);

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign w_ext_a = {{32{w_smul & i_a[31]}}, i_a};
    assign w_ext_b = {{32{w_smul & i_b[31]}}, i_b};
    assign o_prod  = w_ext_a * w_ext_b;

    // Signed divide via magnitudes: quotient truncates toward zero, remainder
    // follows the dividend's sign; also sidesteps the INT_MIN / -1 corner.
    assign w_mag_a    = (w_sdiv && i_a[31]) ? (~i_a + 32'd1) : i_a;
    assign w_mag_b    = (w_sdiv && i_b[31]) ? (~i_b + 32'd1) : i_b;
    assign o_div_zero = (i_b == 32'd0);
    assign w_uq       = o_div_zero ? 32'd0 : (w_mag_a / w_mag_b);
    assign w_ur       = o_div_zero ? 32'd0 : (w_mag_a % w_mag_b);
    assign o_quot     = (w_sdiv && (i_a[31] ^ i_b[31])) ? (~w_uq + 32'd1) : w_uq;
    assign o_rem      = (w_sdiv && i_a[31]) ? (~w_ur + 32'd1) : w_ur;

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: busy countdown, result staging, HI/LO
// architectural registers and the ID-stage stall request.
import mdu_ctrl_pkg::*;

module mdu_ctrl #(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdOp,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        mdInstr_D,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        stallReq
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_stage_hi;
    logic [31:0]      r_stage_lo;
    logic             r_stage_wr;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic [63:0]      w_prod;
    logic [31:0]      w_quot;
    logic [31:0]      w_rem;
    logic             w_div_zero;

    mdu_arith u_arith (
        .i_op       (mdOp),
        .i_a        (srcA),
        .i_b        (srcB),
        .o_prod     (w_prod),
        .o_quot     (w_quot),
        .o_rem      (w_rem),
        .o_div_zero (w_div_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_stage_hi <= '0;
            r_stage_lo <= '0;
            r_stage_wr <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1) && r_stage_wr) begin
                r_hi <= r_stage_hi;
                r_lo <= r_stage_lo;
            end
        end else if (start) begin
            case (mdOp)
                MD_MULT, MD_MULTU: begin
                    r_stage_hi <= w_prod[63:32];
                    r_stage_lo <= w_prod[31:0];
                    r_stage_wr <= 1'b1;
                    r_cnt      <= CNT_W'(MULT_CYCLES);
                end
                MD_DIV, MD_DIVU: begin
                    r_stage_hi <= w_rem;
                    r_stage_lo <= w_quot;
                    // Divide by zero still takes the full time but commits nothing.
                    r_stage_wr <= ~w_div_zero;
                    r_cnt      <= CNT_W'(DIV_CYCLES);
                end
                MD_MTHI: r_hi <= srcA;
                MD_MTLO: r_lo <= srcA;
                default: ;
            endcase
        end
    end

    assign busy     = (r_cnt != '0);
    assign HI       = r_hi;
    assign LO       = r_lo;
    assign stallReq = mdInstr_D & (busy | (start & is_timed_op(mdOp)));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: timing-level reference model checked every
// cycle, plus literal expectations for the key scenarios.
import mdu_ctrl_pkg::*;

module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  mdOp = 3'd0;
    logic [31:0] srcA = 32'd0;
    logic [31:0] srcB = 32'd0;
    logic        mdInstr_D = 1'b0;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        stallReq;

    int total = 0;
    int bad   = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mdOp      (mdOp),
        .srcA      (srcA),
        .srcB      (srcB),
        .mdInstr_D (mdInstr_D),
        .busy      (busy),
        .HI        (HI),
        .LO        (LO),
        .stallReq  (stallReq)
    );

    always #5 clk = ~clk;

    // Reference model: each op is a time window [start edge, start edge + N);
    // results commit at the edge that closes the window.
    longint      m_edge  = 0;
    longint      m_done  = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
    logic        m_pwr = 1'b0;

    always @(posedge clk) begin
        longint sa, sb, sq, sr;
        longint unsigned ua, ub, up;
        m_edge = m_edge + 1;
        if (reset) begin
            m_hi = 0; m_lo = 0; m_done = 0; m_pwr = 1'b0; m_valid = 1'b1;
        end else begin
            if (m_edge == m_done && m_pwr) begin
                m_hi = m_phi; m_lo = m_plo;
            end
            if (!((m_edge - 1) < m_done) && start) begin
                sa = longint'($signed(srcA)); sb = longint'($signed(srcB));
                ua = {32'd0, srcA};           ub = {32'd0, srcB};
                case (mdOp)
                    MD_MULT:  begin up = longint'(sa * sb); m_phi = up[63:32]; m_plo = up[31:0];
                                    m_pwr = 1'b1; m_done = m_edge + 5; end
                    MD_MULTU: begin up = ua * ub;           m_phi = up[63:32]; m_plo = up[31:0];
                                    m_pwr = 1'b1; m_done = m_edge + 5; end
                    MD_DIV:   begin m_pwr = (srcB != 0); m_done = m_edge + 10;
                                    if (m_pwr) begin sq = sa / sb; sr = sa % sb;
                                        m_plo = sq[31:0]; m_phi = sr[31:0]; end end
                    MD_DIVU:  begin m_pwr = (srcB != 0); m_done = m_edge + 10;
                                    if (m_pwr) begin m_plo = 32'(ua / ub); m_phi = 32'(ua % ub); end end
                    MD_MTHI:  m_hi = srcA;
                    MD_MTLO:  m_lo = srcA;
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        logic e_busy, e_stall;
        if (m_valid) begin
            e_busy  = (m_edge < m_done);
            e_stall = mdInstr_D & (e_busy | (start & (mdOp inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU})));
            check("cyc busy", {31'd0, busy}, {31'd0, e_busy});
            check("cyc stallReq", {31'd0, stallReq}, {31'd0, e_stall});
            check("cyc HI", HI, m_hi);
            check("cyc LO", LO, m_lo);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        mdOp = op; srcA = a; srcB = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Count busy cycles from the current point; returns at the first idle negedge.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) return;
            n++;
        end
        total++; bad++;
        $display("FAIL busy timeout: got busy after 40 cycles expected idle");
    endtask

    int n;

    initial begin
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset HI", HI, 32'd0);
        check("reset LO", LO, 32'd0);
        tick();

        issue(MD_MULT, 32'd3, 32'hFFFF_FFFE);
        count_busy(n);
        check("mult busy len", n, 32'd5);
        check("mult HI", HI, 32'hFFFF_FFFF);
        check("mult LO", LO, 32'hFFFF_FFFA);
        tick();

        issue(MD_DIVU, 32'd7, 32'd2);
        count_busy(n);
        check("divu busy len", n, 32'd10);
        check("divu LO", LO, 32'd3);
        check("divu HI", HI, 32'd1);
        tick();

        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        count_busy(n);
        check("div LO", LO, 32'hFFFF_FFFD);
        check("div HI", HI, 32'hFFFF_FFFF);
        tick();

        issue(MD_MTHI, 32'h1234_5678, 32'd0);
        @(negedge clk);
        check("mthi busy", {31'd0, busy}, 32'd0);
        check("mthi HI", HI, 32'h1234_5678);
        tick();
        issue(MD_DIV, 32'd100, 32'd0);
        count_busy(n);
        check("div0 busy len", n, 32'd10);
        check("div0 HI", HI, 32'h1234_5678);
        check("div0 LO", LO, 32'hFFFF_FFFD);
        tick();

        // stall on an idle-cycle start of a timed op
        mdInstr_D = 1'b1; mdOp = MD_DIVU; start = 1'b1;
        #1 check("stall idle start", {31'd0, stallReq}, 32'd1);
        start = 1'b0;
        tick();

        issue(MD_MULT, 32'h0001_0000, 32'h0001_0000);
        tick();
        issue(MD_MULTU, 32'd5, 32'd5);
        @(negedge clk);
        check("stall while busy", {31'd0, stallReq}, 32'd1);
        n = 0;
        if (busy) begin count_busy(n); n++; end
        check("ignored start remaining", n, 32'd3);
        check("ignored HI", HI, 32'd1);
        check("ignored LO", LO, 32'd0);
        mdInstr_D = 1'b0;
        tick();

        issue(MD_MTLO, 32'hA5A5_0001, 32'd0);
        issue(MD_DIV, 32'd9, 32'd2);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst mid busy", {31'd0, busy}, 32'd0);
        check("rst mid HI", HI, 32'd0);
        check("rst mid LO", LO, 32'd0);
        repeat (14) tick();
        check("no late HI", HI, 32'd0);
        check("no late LO", LO, 32'd0);

        // reset wins over start
        reset = 1'b1; mdOp = MD_MULT; srcA = 32'd2; srcB = 32'd2; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("reset prio busy", {31'd0, busy}, 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
